// File: rtl/ttfir_decim_pkg.sv
// Shared widths and saturation limits for the FIR output path (FIR core,
// decimator and bench all take their defaults from here).
package ttfir_decim_pkg;

    localparam int BW_IN_DEF        = 8;
    localparam int BW_OUT_DEF       = 8;
    localparam int LOG2_DEC_MAX_DEF = 3;
    localparam int GAIN_W           = 2;
    localparam int GAIN_MAX         = 3;

    function automatic int sat_max(input int bw);
        return (1 << (bw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int bw);
        return -(1 << (bw - 1));
    endfunction

    // Group sum plus one rounding bit plus the largest gain shift never wraps.
    function automatic int wide_w(input int bw_in, input int log2_dec_max);
        return bw_in + log2_dec_max + 1 + GAIN_MAX;
    endfunction

endpackage

// File: rtl/ttfir_rnd_sat.sv
// Combinational round-half-up divide by 2^k, power-of-two gain, and
// saturation to the output width with an overflow flag.
module ttfir_rnd_sat
    import ttfir_decim_pkg::*;
#(
    parameter  int BW_in        = BW_IN_DEF,
    parameter  int BW_out       = BW_OUT_DEF,
    parameter  int LOG2_DEC_MAX = LOG2_DEC_MAX_DEF,
    localparam int KW           = $clog2(LOG2_DEC_MAX + 1),
    localparam int W            = wide_w(BW_in, LOG2_DEC_MAX)
) (
    input  logic signed [W-1:0]      s,
    input  logic        [KW-1:0]     k,
    input  logic        [GAIN_W-1:0] gain,
    output logic signed [BW_out-1:0] y,
    output logic                     ovf
);

    localparam logic signed [W-1:0] MAX_W = W'(sat_max(BW_out));
    localparam logic signed [W-1:0] MIN_W = W'(sat_min(BW_out));

    logic signed [W-1:0] bias;
    logic signed [W-1:0] rounded;
    logic signed [W-1:0] g;

    always_comb begin
        bias = '0;
        if (k != '0) begin
            bias = W'(1) <<< (k - KW'(1));
        end
        // Arithmetic shift floors, so adding half an LSB first rounds half-up.
        rounded = (s + bias) >>> k;
        g       = rounded <<< gain;

        y   = g[BW_out-1:0];
        ovf = 1'b0;
        if (g > MAX_W) begin
            y   = MAX_W[BW_out-1:0];
            ovf = 1'b1;
        end else if (g < MIN_W) begin
            y   = MIN_W[BW_out-1:0];
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/ttfir_decim.sv
// Accumulate-and-dump decimator behind the FIR core: averages 2^k valid
// samples, rounds, applies gain, saturates, and strobes one result per group.
module ttfir_decim
    import ttfir_decim_pkg::*;
#(
    parameter  int BW_in        = BW_IN_DEF,
    parameter  int BW_out       = BW_OUT_DEF,
    parameter  int LOG2_DEC_MAX = LOG2_DEC_MAX_DEF,
    localparam int KW           = $clog2(LOG2_DEC_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [BW_in-1:0]  x_in,
    input  logic                     x_valid,
    input  logic        [KW-1:0]     dec_sel,
    input  logic        [GAIN_W-1:0] gain,
    output logic signed [BW_out-1:0] y_out,
    output logic                     y_valid,
    output logic                     ovf
);

    // Handshake: x_valid qualifies x_in on every rising edge with no
    // backpressure; y_valid is a one-cycle strobe qualifying y_out and ovf,
    // and y_out holds its last value while y_valid is low.

    localparam int ACC_W = BW_in + LOG2_DEC_MAX;
    localparam int W     = wide_w(BW_in, LOG2_DEC_MAX);
    localparam int CW    = LOG2_DEC_MAX;

    logic signed [ACC_W-1:0]  acc;
    logic        [CW-1:0]     cnt;
    logic        [KW-1:0]     k_act;

    logic        [KW-1:0]     k_sel;
    logic        [CW-1:0]     last_cnt;
    logic                     is_dump;
    logic signed [ACC_W-1:0]  x_acc;
    logic signed [W-1:0]      s_wide;
    logic signed [BW_out-1:0] y_sat;
    logic                     ovf_sat;

    always_comb begin
        k_sel = dec_sel;
        if (int'(dec_sel) > LOG2_DEC_MAX) begin
            k_sel = KW'(LOG2_DEC_MAX);
        end
    end

    always_comb begin
        last_cnt = CW'((32'd1 << k_act) - 32'd1);
        is_dump  = x_valid && (cnt == last_cnt);
        x_acc    = {{(ACC_W - BW_in){x_in[BW_in-1]}}, x_in};
        // The final sum is formed wide so the rounding add cannot wrap.
        s_wide   = {{(W - ACC_W){acc[ACC_W-1]}}, acc}
                 + {{(W - BW_in){x_in[BW_in-1]}}, x_in};
    end

    ttfir_rnd_sat #(
        .BW_in       (BW_in),
        .BW_out      (BW_out),
        .LOG2_DEC_MAX(LOG2_DEC_MAX)
    ) u_rnd_sat (
        .s   (s_wide),
        .k   (k_act),
        .gain(gain),
        .y   (y_sat),
        .ovf (ovf_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            k_act   <= k_sel;
            y_out   <= '0;
            y_valid <= 1'b0;
            ovf     <= 1'b0;
        end else if (is_dump) begin
            acc     <= '0;
            cnt     <= '0;
            k_act   <= k_sel;
            y_out   <= y_sat;
            y_valid <= 1'b1;
            ovf     <= ovf_sat;
        end else begin
            if (x_valid) begin
                acc <= acc + x_acc;
                cnt <= cnt + CW'(1);
            end
            y_valid <= 1'b0;
            ovf     <= 1'b0;
        end
    end

endmodule
